// File: rtl/memory_bus_arbiter.sv
// Memory bus arbiter: shares one external memory bus between instruction fetch and the
// memory stage's loads/stores. The memory stage wins by default. Under contention the two
// requesters alternate, so fetch gets at least every second slot.
//
// Each transfer puts address/width/data and a strobe on the bus, then waits for bus_ack.
// The transfer is aborted with bus_error if the ack has not arrived after TIMEOUT_CYCLES
// strobe cycles (0 disables the timeout).
//
// Ports:
//   clock, reset          system clock; asynchronous active-high reset
//   fetch_*               fetch request/address in; done pulse and instruction word out
//   data_*                load/store request, direction, width, address, wdata in;
//                         done pulse and load data out
//   bus_error             pulses with a done when that transfer timed out
//   fetch_stalled         fetch is requesting but does not own the bus (combinational)
//   bus_*                 registered memory bus: address, wdata, read/write strobes, width;
//                         rdata and ack in
module memory_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [1:0]  FETCH_WIDTH    = 2'b00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic        fetch_done,
  output logic [31:0] fetch_data,
  input  logic        data_req,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_address,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        bus_error,
  output logic        fetch_stalled,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  output logic        bus_read,
  output logic        bus_write,
  output logic [1:0]  bus_width,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned   CntW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit            TimeoutEn = (TIMEOUT_CYCLES != 0);

  state_e          state_q, state_d;
  logic [31:0]     bus_address_q, bus_address_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic            bus_read_q, bus_read_d;
  logic            bus_write_q, bus_write_d;
  logic [1:0]      bus_width_q, bus_width_d;
  logic [31:0]     fetch_data_q, fetch_data_d;
  logic [31:0]     data_rdata_q, data_rdata_d;
  logic            fetch_done_q, fetch_done_d;
  logic            data_done_q, data_done_d;
  logic            bus_error_q, bus_error_d;
  logic            last_was_data_q, last_was_data_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d         = state_q;
    bus_address_d   = bus_address_q;
    bus_wdata_d     = bus_wdata_q;
    bus_read_d      = bus_read_q;
    bus_write_d     = bus_write_q;
    bus_width_d     = bus_width_q;
    fetch_data_d    = fetch_data_q;
    data_rdata_d    = data_rdata_q;
    fetch_done_d    = 1'b0;
    data_done_d     = 1'b0;
    bus_error_d     = 1'b0;
    last_was_data_d = last_was_data_q;
    cnt_d           = cnt_q;

    unique case (state_q)
      StIdle: begin
        // Data wins unless it had the previous slot and fetch is also waiting.
        if (data_req && !(fetch_req && last_was_data_q)) begin
          state_d         = StData;
          bus_address_d   = data_address;
          bus_width_d     = data_width;
          bus_read_d      = data_read;
          bus_write_d     = data_write && !data_read;
          if (data_write) bus_wdata_d = data_wdata;
          last_was_data_d = 1'b1;
          cnt_d           = '0;
        end else if (fetch_req) begin
          state_d         = StFetch;
          bus_address_d   = fetch_address;
          bus_width_d     = FETCH_WIDTH;
          bus_read_d      = 1'b1;
          bus_write_d     = 1'b0;
          last_was_data_d = 1'b0;
          cnt_d           = '0;
        end
      end
      StFetch, StData: begin
        if (bus_ack) begin
          if (state_q == StFetch) begin
            fetch_data_d = bus_rdata;
          end else if (bus_read_q) begin
            data_rdata_d = bus_rdata;
          end
          fetch_done_d = (state_q == StFetch);
          data_done_d  = (state_q == StData);
          bus_read_d   = 1'b0;
          bus_write_d  = 1'b0;
          state_d      = StIdle;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          // Abort: captured data stays as it was.
          fetch_done_d = (state_q == StFetch);
          data_done_d  = (state_q == StData);
          bus_error_d  = 1'b1;
          bus_read_d   = 1'b0;
          bus_write_d  = 1'b0;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d     = StIdle;
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      bus_address_q   <= '0;
      bus_wdata_q     <= '0;
      bus_read_q      <= 1'b0;
      bus_write_q     <= 1'b0;
      bus_width_q     <= FETCH_WIDTH;
      fetch_data_q    <= '0;
      data_rdata_q    <= '0;
      fetch_done_q    <= 1'b0;
      data_done_q     <= 1'b0;
      bus_error_q     <= 1'b0;
      last_was_data_q <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      bus_address_q   <= bus_address_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_read_q      <= bus_read_d;
      bus_write_q     <= bus_write_d;
      bus_width_q     <= bus_width_d;
      fetch_data_q    <= fetch_data_d;
      data_rdata_q    <= data_rdata_d;
      fetch_done_q    <= fetch_done_d;
      data_done_q     <= data_done_d;
      bus_error_q     <= bus_error_d;
      last_was_data_q <= last_was_data_d;
      cnt_q           <= cnt_d;
    end
  end

  assign fetch_done    = fetch_done_q;
  assign fetch_data    = fetch_data_q;
  assign data_done     = data_done_q;
  assign data_rdata    = data_rdata_q;
  assign bus_error     = bus_error_q;
  assign bus_address   = bus_address_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_read      = bus_read_q;
  assign bus_write     = bus_write_q;
  assign bus_width     = bus_width_q;
  assign fetch_stalled = fetch_req && (state_q != StFetch);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios, a transaction-level reference model
// compared on every falling edge, and literal expectations at key points.
module tb_memory_bus_arbiter;

  localparam int unsigned TO = 4;
  localparam logic [1:0]  FW = 2'b00;

  logic        clock, reset;
  logic        fetch_req, fetch_done, data_req, data_read, data_write, data_done;
  logic [31:0] fetch_address, fetch_data, data_address, data_wdata, data_rdata;
  logic [1:0]  data_width, bus_width;
  logic        bus_error, fetch_stalled, bus_read, bus_write, bus_ack;
  logic [31:0] bus_address, bus_wdata, bus_rdata;

  memory_bus_arbiter #(.TIMEOUT_CYCLES(TO), .FETCH_WIDTH(FW)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_done(fetch_done),
    .fetch_data(fetch_data),
    .data_req(data_req), .data_read(data_read), .data_write(data_write),
    .data_width(data_width), .data_address(data_address), .data_wdata(data_wdata),
    .data_done(data_done), .data_rdata(data_rdata),
    .bus_error(bus_error), .fetch_stalled(fetch_stalled),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_read(bus_read),
    .bus_write(bus_write), .bus_width(bus_width), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data) and how many cycles the
  // strobe has been up; a transfer ends on ack, or with an error once the strobe has
  // been up TO cycles.
  int          m_owner, m_age;
  logic        m_read, m_write, m_fdone, m_ddone, m_err, m_last_data;
  logic [31:0] m_addr, m_wdata, m_fdata, m_rdata;
  logic [1:0]  m_width;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_owner <= 0; m_age <= 0; m_read <= 0; m_write <= 0;
      m_fdone <= 0; m_ddone <= 0; m_err <= 0; m_last_data <= 0;
      m_addr <= 0; m_wdata <= 0; m_fdata <= 0; m_rdata <= 0; m_width <= FW;
    end else begin
      m_fdone <= 0; m_ddone <= 0; m_err <= 0;
      if (m_owner == 0) begin
        if (data_req && !(fetch_req && m_last_data)) begin
          m_owner <= 2; m_age <= 1; m_last_data <= 1;
          m_addr <= data_address; m_width <= data_width;
          m_read <= data_read; m_write <= data_write;
          if (data_write) m_wdata <= data_wdata;
        end else if (fetch_req) begin
          m_owner <= 1; m_age <= 1; m_last_data <= 0;
          m_addr <= fetch_address; m_width <= FW; m_read <= 1; m_write <= 0;
        end
      end else if (bus_ack) begin
        if (m_owner == 1) begin m_fdone <= 1; m_fdata <= bus_rdata; end
        else begin m_ddone <= 1; if (m_read) m_rdata <= bus_rdata; end
        m_owner <= 0; m_read <= 0; m_write <= 0;
      end else if (TO != 0 && m_age == TO) begin
        if (m_owner == 1) m_fdone <= 1; else m_ddone <= 1;
        m_err <= 1; m_owner <= 0; m_read <= 0; m_write <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("cmp_bus_read", bus_read, m_read);
    chk("cmp_bus_write", bus_write, m_write);
    chk("cmp_bus_address", bus_address, m_addr);
    chk("cmp_bus_wdata", bus_wdata, m_wdata);
    chk("cmp_bus_width", bus_width, m_width);
    chk("cmp_fetch_done", fetch_done, m_fdone);
    chk("cmp_data_done", data_done, m_ddone);
    chk("cmp_bus_error", bus_error, m_err);
    chk("cmp_fetch_data", fetch_data, m_fdata);
    chk("cmp_data_rdata", data_rdata, m_rdata);
    chk("cmp_fetch_stalled", fetch_stalled, fetch_req && (m_owner != 1));
  end

  // Memory responder: ack after ack_wait strobe cycles (negative = never).
  int ack_wait   = 0;
  int strobe_cnt = 0;
  logic force_ack = 1'b0;

  task automatic step();
    @(posedge clock);
    #1;
    if (bus_read || bus_write) begin
      bus_ack = (ack_wait >= 0) && (strobe_cnt == ack_wait);
      strobe_cnt++;
    end else begin
      strobe_cnt = 0;
      bus_ack = force_ack;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int grants[4];
  int n_grants;

  initial begin
    reset = 1'b1;
    fetch_req = 0; fetch_address = 0; data_req = 0; data_read = 0; data_write = 0;
    data_width = 0; data_address = 0; data_wdata = 0; bus_rdata = 0; bus_ack = 0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_bus_read", bus_read, 1'b0);
    chk("rst_bus_width", bus_width, FW);
    chk("rst_bus_address", bus_address, 32'h0);
    chk("rst_fetch_data", fetch_data, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);

    // Zero-wait fetch
    fetch_req = 1; fetch_address = 32'h100; bus_rdata = 32'hDEADBEEF; ack_wait = 0;
    step();
    chk("f_bus_read", bus_read, 1'b1);
    chk("f_bus_address", bus_address, 32'h100);
    chk("f_bus_width", bus_width, 2'b00);
    chk("f_model_addr", m_addr, 32'h100);
    step();
    chk("f_done", fetch_done, 1'b1);
    chk("f_data", fetch_data, 32'hDEADBEEF);
    chk("f_err", bus_error, 1'b0);
    chk("f_strobe_drop", bus_read, 1'b0);
    fetch_req = 0;
    step();
    chk("f_done_once", fetch_done, 1'b0);

    // Store with 3 wait cycles; requester inputs change mid-transfer and are ignored
    data_req = 1; data_write = 1; data_read = 0; data_width = 2'b10;
    data_address = 32'h2000; data_wdata = 32'h12345678; ack_wait = 3;
    bus_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s_bus_write", bus_write, 1'b1);
      chk("s_bus_address", bus_address, 32'h2000);
      chk("s_bus_wdata", bus_wdata, 32'h12345678);
      chk("s_bus_width", bus_width, 2'b10);
      chk("s_no_done", data_done, 1'b0);
      data_address = 32'h0BAD0BAD; data_wdata = 32'h0;
    end
    step();
    chk("s_done", data_done, 1'b1);
    chk("s_strobe_drop", bus_write, 1'b0);
    chk("s_rdata_kept", data_rdata, 32'h0);
    chk("s_err", bus_error, 1'b0);
    data_req = 0; data_write = 0;
    step();
    chk("s_done_once", data_done, 1'b0);

    // Reset during the ack wait of a fetch
    fetch_req = 1; fetch_address = 32'h300; ack_wait = -1;
    step();
    chk("r_bus_read", bus_read, 1'b1);
    step(); step();
    reset = 1'b1; fetch_req = 0;
    #1;
    chk("r_strobe_clear", bus_read, 1'b0);
    chk("r_addr_clear", bus_address, 32'h0);
    chk("r_fetch_data_clear", fetch_data, 32'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_no_done", fetch_done, 1'b0);
    end

    // Contention: both held, grants alternate starting with data
    ack_wait = 0; bus_rdata = 32'h11112222;
    fetch_address = 32'h400; data_address = 32'h500; data_read = 1; data_width = 2'b01;
    fetch_req = 1; data_req = 1;
    n_grants = 0;
    for (int i = 0; i < 20 && n_grants < 4; i++) begin
      step();
      if (bus_read && bus_address == 32'h500) chk("a_stalled_data", fetch_stalled, 1'b1);
      if (bus_read && bus_address == 32'h400) chk("a_stalled_fetch", fetch_stalled, 1'b0);
      if (data_done) begin grants[n_grants] = 0; n_grants++; end
      if (fetch_done && n_grants < 4) begin grants[n_grants] = 1; n_grants++; end
    end
    fetch_req = 0; data_req = 0; data_read = 0;
    chk("a_grant_count", n_grants, 4);
    for (int i = 0; i < 4; i++) chk("a_grant_order", grants[i], (i % 2));
    step();

    // Stray ack while idle, then a zero-wait load
    force_ack = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("i_no_ddone", data_done, 1'b0);
      chk("i_no_fdone", fetch_done, 1'b0);
    end
    force_ack = 0;
    data_req = 1; data_read = 1; data_write = 0; data_address = 32'h40;
    data_width = 2'b10; bus_rdata = 32'h55; ack_wait = 0;
    step();
    chk("l_bus_read", bus_read, 1'b1);
    chk("l_bus_address", bus_address, 32'h40);
    step();
    chk("l_done", data_done, 1'b1);
    chk("l_rdata", data_rdata, 32'h55);
    data_req = 0; data_read = 0;
    step();

    // Timeout on a load with no ack
    data_req = 1; data_read = 1; data_address = 32'h80; bus_rdata = 32'h77; ack_wait = -1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t_strobe", bus_read, 1'b1);
      chk("t_no_done", data_done, 1'b0);
      chk("t_no_err", bus_error, 1'b0);
    end
    step();
    chk("t_done", data_done, 1'b1);
    chk("t_err", bus_error, 1'b1);
    chk("t_strobe_drop", bus_read, 1'b0);
    chk("t_rdata_kept", data_rdata, 32'h55);
    data_req = 0; data_read = 0;
    step();
    chk("t_err_once", bus_error, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares the single external memory bus between two requesters: instruction fetch and the memory pipeline stage's load/store accesses.
- The memory stage is the high-priority requester, driven by its memory_access_cycle/read/write/width/index outputs resolved to addresses and data.
- Sequences each bus transfer through an address/strobe phase and an acknowledge wait.
- Provides a timeout error and anti-starvation alternation so fetch is never locked out by back-to-back loads/stores.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in a busy state without bus_ack before the transfer is aborted with an error; 0 disables the timeout.
- FETCH_WIDTH, 2'b00: cycle width driven for instruction fetches (2'b00 = 32-bit long).

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- fetch_req  input  1  fetch requests a transfer; held until fetch_done
- fetch_address  input  32  fetch byte address
- fetch_done  output  1  one-cycle pulse: fetch transfer finished
- fetch_data  output  32  instruction word, valid with fetch_done
- data_req  input  1  memory stage requests a transfer; held until data_done
- data_read  input  1  1 = load
- data_write  input  1  1 = store; exactly one of data_read/data_write is set when data_req is high
- data_width  input  2  t_cycle_width of the access
- data_address  input  32  load/store byte address
- data_wdata  input  32  store data
- data_done  output  1  one-cycle pulse: data transfer finished
- data_rdata  output  32  load data, valid with data_done
- bus_error  output  1  one-cycle pulse with fetch_done/data_done when the transfer timed out
- fetch_stalled  output  1  high while fetch_req is pending but not owning the bus
- bus_address  output  32  memory address
- bus_wdata  output  32  memory write data
- bus_read  output  1  read strobe
- bus_write  output  1  write strobe
- bus_width  output  2  t_cycle_width of the current cycle
- bus_rdata  input  32  memory read data
- bus_ack  input  1  memory completes the current cycle; sampled only while a strobe is high

Behaviour:
- Reset, asynchronous:
  - state=IDLE; all strobes, done pulses and bus_error = 0.
  - bus_address, bus_wdata, fetch_data, data_rdata = 0.
  - bus_width = FETCH_WIDTH; last_was_data = 0; timeout counter = 0.
  - A reset during a transfer drops the strobes immediately and loses the transfer. Requesters must re-request.
- States: IDLE, FETCH, DATA. All outputs are registered except fetch_stalled, which is combinational: fetch_req && state!=FETCH.
- IDLE arbitration, at each edge:
  - If only data_req: grant DATA.
  - If only fetch_req: grant FETCH.
  - If both: grant DATA unless last_was_data=1, in which case grant FETCH. Data wins by default; fetch is guaranteed every second slot under contention.
  - If neither: stay IDLE.
- On grant:
  - Latch address, width (FETCH_WIDTH for fetch) and wdata (stores) onto the bus outputs.
  - Set bus_read or bus_write; bus_read=1 for fetch.
  - Clear the counter; last_was_data = (grant==DATA).
- In FETCH/DATA:
  - Bus outputs are held stable until completion; requester input changes are ignored.
  - On an edge with bus_ack=1: capture bus_rdata into fetch_data or data_rdata (reads only; data_rdata is unchanged on stores). Pulse the matching done for one cycle, drop the strobes, return to IDLE.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack (TIMEOUT_CYCLES>0): pulse done and bus_error together, leave captured data unchanged, drop the strobes, return to IDLE.
- Latency:
  - A request seen at edge N puts the strobes up after N.
  - A zero-wait ack at edge N+1 gives done high during cycle N+1..N+2.
  - A transfer occupies at least 2 cycles including the IDLE re-arbitration cycle; no back-to-back strobes.
- Dropping a request mid-transfer does not abort it; done still pulses.
- A done pulse coincides with the IDLE cycle. Requesters must deassert req on the cycle done is seen, or they are re-arbitrated on the next edge.
- bus_read and bus_write are never both high.
- bus_ack while in IDLE is ignored.

Test Plan:
- Reset then fetch_req with fetch_address=0x100 and zero-wait ack returning bus_rdata=0xDEADBEEF:
  - bus_read=1, bus_address=0x100, bus_width=2'b00 for one cycle.
  - Then fetch_done=1 with fetch_data=0xDEADBEEF; bus_error=0.
- Store with data_address=0x2000, wdata=0x12345678, width=2'b10, 3 wait cycles: bus_write held high 4 cycles with stable address/wdata/width, then data_done pulses once and data_rdata is unchanged.
- fetch_req and data_req held continuously: grants alternate DATA, FETCH, DATA, FETCH; fetch_stalled is high during DATA ownership.
- TIMEOUT_CYCLES=4 with bus_ack held 0 on a load: strobe high 4 cycles, then data_done=1 and bus_error=1 in the same cycle, and the strobe drops.
- Assert reset during the wait of a fetch: strobes and state clear immediately, and no fetch_done is produced.
- bus_ack pulsed while IDLE, then data_req load at 0x40 with ack returning 0x55: no spurious done; data_rdata=0x55 on data_done.
